rst_sequencer: RTL and testbench

Reset/flush controller for the async FIFO and the MAC logic it feeds, in one clock domain. It merges power-on, software and error reset sources. It sequences a flush handshake with the peer clock domain of the FIFO. It then releases the FIFO reset and the MAC reset in a fixed order with a guaranteed gap between them.

---
 rtl/rst_sequencer.sv | 132 +++++++++++++
 tb/tb_rst_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// Reset/flush sequencer for the async FIFO and the MAC behind it.
// Merges reset sources, runs the peer flush handshake, then releases resets in order.
module rst_sequencer #(
  parameter int HOLD_CYCLES = 16,
  parameter int ACK_TIMEOUT = 255,
  parameter int SYNC_STAGES = 2,
  parameter int REL_GAP     = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       soft_rst_req,
  input  logic       err_rst_req,
  input  logic       peer_ack,
  input  logic       err_clr,
  output logic       n_fifo_rst,
  output logic       n_mac_rst,
  output logic       flush_req,
  output logic       busy,
  output logic       timeout_err,
  output logic [1:0] rst_cause
);

  localparam int M1   = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
  localparam int MAXC = (M1 > REL_GAP) ? M1 : REL_GAP;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(REL_GAP - 1);

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_HS,
    ST_DROP,
    ST_REL,
    ST_RUN
  } state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n, cnt_inc;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;
  logic                   to_set;
  logic                   te_n;
  logic [1:0]             cause_n;

  assign ack_s   = sync_q[SYNC_STAGES-1];
  assign cnt_inc = (cnt == '1) ? cnt : cnt + CW'(1);

  always_comb begin
    state_n = state;
    cnt_n   = cnt_inc;
    cause_n = rst_cause;
    to_set  = 1'b0;
    unique case (state)
      ST_ASSERT: begin
        if (cnt == HOLD_LAST) begin
          state_n = ST_HS;
          cnt_n   = '0;
        end
      end
      ST_HS: begin
        if (ack_s || cnt == ACK_LAST) begin
          state_n = ST_DROP;
          cnt_n   = '0;
          to_set  = !ack_s;
        end
      end
      ST_DROP: begin
        if (!ack_s || cnt == ACK_LAST) begin
          state_n = ST_REL;
          cnt_n   = '0;
          to_set  = ack_s;
        end
      end
      ST_REL: begin
        if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if (err_rst_req) begin
            state_n = ST_ASSERT;
            cause_n = 2'b10;
          end else begin
            state_n = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        cnt_n = '0;
        if (err_rst_req) begin
          state_n = ST_ASSERT;
          cause_n = 2'b10;
        end else if (soft_rst_req) begin
          state_n = ST_ASSERT;
          cause_n = 2'b01;
        end
      end
      default: begin
        state_n = ST_ASSERT;
        cnt_n   = '0;
      end
    endcase
    // a new timeout outranks a clear on the same edge
    te_n = timeout_err;
    if (err_clr) te_n = 1'b0;
    if (to_set)  te_n = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= ST_ASSERT;
      cnt         <= '0;
      sync_q      <= '0;
      n_fifo_rst  <= 1'b0;
      n_mac_rst   <= 1'b0;
      flush_req   <= 1'b0;
      busy        <= 1'b1;
      timeout_err <= 1'b0;
      rst_cause   <= 2'b00;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], peer_ack};
      n_fifo_rst  <= (state_n == ST_REL) || (state_n == ST_RUN);
      n_mac_rst   <= (state_n == ST_RUN);
      flush_req   <= (state_n == ST_HS);
      busy        <= (state_n != ST_RUN);
      timeout_err <= te_n;
      rst_cause   <= cause_n;
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer.
// Expected output vectors are queued per edge and compared after that edge.
module tb_rst_sequencer;

  logic       clk;
  logic       n_rst;
  logic       soft_rst_req;
  logic       err_rst_req;
  logic       peer_ack;
  logic       err_clr;
  logic       n_fifo_rst;
  logic       n_mac_rst;
  logic       flush_req;
  logic       busy;
  logic       timeout_err;
  logic [1:0] rst_cause;
  logic       loop;

  rst_sequencer dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .soft_rst_req (soft_rst_req),
    .err_rst_req  (err_rst_req),
    .peer_ack     (peer_ack),
    .err_clr      (err_clr),
    .n_fifo_rst   (n_fifo_rst),
    .n_mac_rst    (n_mac_rst),
    .flush_req    (flush_req),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .rst_cause    (rst_cause)
  );

  assign peer_ack = loop ? flush_req : 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         e;
    string      tag;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];
  int   ecnt;
  int   checks;
  int   errors;
  int   base;

  function automatic logic [6:0] v(
    input logic nf, input logic nm, input logic fr,
    input logic bz, input logic te, input logic [1:0] c
  );
    return {nf, nm, fr, bz, te, c};
  endfunction

  task automatic p(input int e, input string tag, input logic [6:0] val);
    exp_t x;
    x.e   = e;
    x.tag = tag;
    x.v   = val;
    sb.push_back(x);
  endtask

  task automatic drain();
    logic [6:0] obs;
    exp_t       x;
    while (sb.size() > 0 && sb[0].e <= ecnt) begin
      x   = sb.pop_front();
      obs = {n_fifo_rst, n_mac_rst, flush_req, busy, timeout_err, rst_cause};
      checks++;
      assert (x.e == ecnt && obs === x.v) else begin
        errors++;
        $error("FAIL %s edge %0d: got %b want %b (due edge %0d)",
               x.tag, ecnt, obs, x.v, x.e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    ecnt++;
    #1;
    drain();
  endtask

  task automatic run_to(input int e);
    while (ecnt < e) tick();
  endtask

  task automatic expect_now(input string tag, input logic [6:0] val);
    p(ecnt, tag, val);
    drain();
  endtask

  // full loopback sequence starting from ASSERT entered at edge b
  task automatic push_seq(input int b, input logic te, input logic [1:0] c);
    p(b + 15, "hold",      v(0, 0, 0, 1, te, c));
    p(b + 16, "hs",        v(0, 0, 1, 1, te, c));
    p(b + 18, "hs_wait",   v(0, 0, 1, 1, te, c));
    p(b + 19, "drop",      v(0, 0, 0, 1, te, c));
    p(b + 21, "drop_wait", v(0, 0, 0, 1, te, c));
    p(b + 22, "rel",       v(1, 0, 0, 1, te, c));
    p(b + 23, "gap",       v(1, 0, 0, 1, te, c));
    p(b + 24, "run",       v(1, 1, 0, 0, te, c));
  endtask

  task automatic push_loop(input int b);
    p(b + 16, "lp_hs",   v(0, 0, 1, 1, 0, 2'b10));
    p(b + 19, "lp_drop", v(0, 0, 0, 1, 0, 2'b10));
    p(b + 22, "lp_rel",  v(1, 0, 0, 1, 0, 2'b10));
    p(b + 23, "lp_gap",  v(1, 0, 0, 1, 0, 2'b10));
    p(b + 24, "lp_back", v(0, 0, 0, 1, 0, 2'b10));
  endtask

  initial begin
    n_rst        = 1'b0;
    soft_rst_req = 1'b0;
    err_rst_req  = 1'b0;
    err_clr      = 1'b0;
    loop         = 1'b1;
    ecnt         = 0;
    checks       = 0;
    errors       = 0;

    repeat (3) tick();
    expect_now("por", v(0, 0, 0, 1, 0, 2'b00));

    // loopback power-on sequence
    n_rst = 1'b1;
    base  = ecnt;
    push_seq(base, 1'b0, 2'b00);
    run_to(base + 28);
    expect_now("run_hold", v(1, 1, 0, 0, 0, 2'b00));

    // peer never acknowledges
    loop  = 1'b0;
    n_rst = 1'b0;
    #1;
    expect_now("s2_rst", v(0, 0, 0, 1, 0, 2'b00));
    tick();
    n_rst = 1'b1;
    base  = ecnt;
    p(base + 16,  "to_hs",    v(0, 0, 1, 1, 0, 2'b00));
    p(base + 270, "to_wait",  v(0, 0, 1, 1, 0, 2'b00));
    p(base + 271, "to_set",   v(0, 0, 0, 1, 1, 2'b00));
    p(base + 272, "to_rel",   v(1, 0, 0, 1, 1, 2'b00));
    p(base + 273, "to_gap",   v(1, 0, 0, 1, 1, 2'b00));
    p(base + 274, "to_run",   v(1, 1, 0, 0, 1, 2'b00));
    run_to(base + 276);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    expect_now("err_clr", v(1, 1, 0, 0, 0, 2'b00));

    // soft and error on the same edge
    loop         = 1'b1;
    soft_rst_req = 1'b1;
    err_rst_req  = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    err_rst_req  = 1'b0;
    expect_now("both_entry", v(0, 0, 0, 1, 0, 2'b10));
    base = ecnt;
    push_seq(base, 1'b0, 2'b10);
    run_to(base + 24);

    // error held through REL keeps looping
    err_rst_req = 1'b1;
    tick();
    expect_now("err_entry", v(0, 0, 0, 1, 0, 2'b10));
    base = ecnt;
    push_loop(base);
    push_loop(base + 24);
    run_to(base + 48);
    base = base + 48;
    push_seq(base, 1'b0, 2'b10);
    run_to(base + 20);
    err_rst_req = 1'b0;
    run_to(base + 24);

    // async abort during handshake
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    expect_now("soft_entry", v(0, 0, 0, 1, 0, 2'b01));
    base = ecnt;
    p(base + 16, "ab_hs", v(0, 0, 1, 1, 0, 2'b01));
    run_to(base + 17);
    #2;
    n_rst = 1'b0;
    #1;
    expect_now("async_abort", v(0, 0, 0, 1, 0, 2'b00));
    tick();
    n_rst = 1'b1;
    base  = ecnt;
    push_seq(base, 1'b0, 2'b00);
    run_to(base + 24);

    // soft request during ASSERT is dropped
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    expect_now("soft2_entry", v(0, 0, 0, 1, 0, 2'b01));
    base = ecnt;
    push_seq(base, 1'b0, 2'b01);
    run_to(base + 5);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    run_to(base + 26);
    expect_now("soft2_run", v(1, 1, 0, 0, 0, 2'b01));

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_left: got %0d entries want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
